// File: rtl/popcnt_pkg.sv
// Shared types and helpers for the sequential population-count controller.
package popcnt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } popcnt_state_t;

    // Bits needed to hold a count of 0..w ones.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/popcnt_chunk.sv
// Combinational popcount of one CHUNK-bit slice; the shared narrow datapath unit.
module popcnt_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0]            bits,
    output logic [$clog2(CHUNK+1)-1:0]  count
);

    localparam int CW = $clog2(CHUNK + 1);

    always_comb begin
        count = '0;
        for (int i = 0; i < CHUNK; i++) begin
            count = count + CW'(bits[i]);
        end
    end

endmodule

// File: rtl/popcnt_seq_ctrl.sv
// Multi-cycle popcount controller: accepts a word, counts it CHUNK bits per cycle
// through one shared popcnt_chunk, and returns count plus zero/one-hot flags.
module popcnt_seq_ctrl
    import popcnt_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int CHUNK      = 4,
    parameter int EARLY_EXIT = 1,
    localparam int CNT_W     = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_count,
    output logic             out_zero,
    output logic             out_onehot,
    output logic             busy
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int PC_W   = $clog2(CHUNK + 1);

    generate
        if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
            $error("popcnt_seq_ctrl: WIDTH must be a positive multiple of CHUNK");
        end
    endgenerate

    popcnt_state_t    state, state_next;
    logic [WIDTH-1:0] shift_reg, remainder;
    logic [CNT_W-1:0] acc, acc_sum;
    logic [IDX_W-1:0] idx;
    logic [PC_W-1:0]  chunk_count;
    logic             last_chunk;
    logic             zero_q, onehot_q;

    popcnt_chunk #(.CHUNK(CHUNK)) u_chunk (
        .bits  (shift_reg[CHUNK-1:0]),
        .count (chunk_count)
    );

    // Handshakes: a transfer happens on a rising clk edge where valid && ready are
    // both high; a producer holds valid and its data stable until that edge.
    always_comb begin
        remainder  = shift_reg >> CHUNK;
        acc_sum    = acc + CNT_W'(chunk_count);
        last_chunk = (idx == IDX_W'(NCHUNK - 1)) ||
                     ((EARLY_EXIT != 0) && (remainder == '0));
        state_next = state;
        case (state)
            IDLE:    if (in_valid)   state_next = BUSY;
            BUSY:    if (last_chunk) state_next = DONE;
            DONE:    if (out_ready)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (flush) state_next = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            shift_reg <= '0;
            acc       <= '0;
            idx       <= '0;
            zero_q    <= 1'b0;
            onehot_q  <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: if (state_next == BUSY) begin
                    shift_reg <= in_data;
                    acc       <= '0;
                    idx       <= '0;
                    zero_q    <= 1'b0;
                    onehot_q  <= 1'b0;
                end
                BUSY: if (!flush) begin
                    shift_reg <= remainder;
                    acc       <= acc_sum;
                    idx       <= idx + IDX_W'(1);
                    // Flags are decoded from the final sum so they are stable in DONE.
                    if (last_chunk) begin
                        zero_q   <= (acc_sum == '0);
                        onehot_q <= (acc_sum == CNT_W'(1));
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready   = (state == IDLE);
    assign out_valid  = (state == DONE);
    assign busy       = (state != IDLE);
    assign out_count  = acc;
    assign out_zero   = zero_q;
    assign out_onehot = onehot_q;

endmodule

// File: tb/tb_popcnt_seq_ctrl.sv
// Directed and randomized checks of popcnt_seq_ctrl (both EARLY_EXIT settings)
// and of the popcnt_chunk unit against a plain behavioural model.
module tb_popcnt_seq_ctrl;

    localparam int WIDTH  = 32;
    localparam int CHUNK  = 4;
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CNT_W  = 6;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             flush = 1'b0;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_valid_f = 1'b0;
    logic             in_valid_e = 1'b0;
    logic             sel = 1'b0;

    logic             f_in_ready, f_out_valid, f_out_zero, f_out_onehot, f_busy;
    logic [CNT_W-1:0] f_out_count;
    logic             e_in_ready, e_out_valid, e_out_zero, e_out_onehot, e_busy;
    logic [CNT_W-1:0] e_out_count;

    logic [CHUNK-1:0] chunk_bits = '0;
    logic [2:0]       chunk_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    popcnt_seq_ctrl #(.WIDTH(WIDTH), .CHUNK(CHUNK), .EARLY_EXIT(0)) u_full (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid_f), .in_ready(f_in_ready), .in_data(in_data),
        .out_valid(f_out_valid), .out_ready(out_ready), .out_count(f_out_count),
        .out_zero(f_out_zero), .out_onehot(f_out_onehot), .busy(f_busy)
    );

    popcnt_seq_ctrl #(.WIDTH(WIDTH), .CHUNK(CHUNK), .EARLY_EXIT(1)) u_early (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid_e), .in_ready(e_in_ready), .in_data(in_data),
        .out_valid(e_out_valid), .out_ready(out_ready), .out_count(e_out_count),
        .out_zero(e_out_zero), .out_onehot(e_out_onehot), .busy(e_busy)
    );

    popcnt_chunk #(.CHUNK(CHUNK)) u_chunk (.bits(chunk_bits), .count(chunk_count));

    wire             s_in_ready   = sel ? e_in_ready   : f_in_ready;
    wire             s_out_valid  = sel ? e_out_valid  : f_out_valid;
    wire [CNT_W-1:0] s_out_count  = sel ? e_out_count  : f_out_count;
    wire             s_out_zero   = sel ? e_out_zero   : f_out_zero;
    wire             s_out_onehot = sel ? e_out_onehot : f_out_onehot;
    wire             s_busy       = sel ? e_busy       : f_busy;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Cycles from the accept edge to the first edge with out_valid high.
    function automatic int model_latency(input logic [WIDTH-1:0] w, input bit early);
        int hi;
        hi = -1;
        if (!early) return NCHUNK;
        for (int b = 0; b < WIDTH; b++) if (w[b]) hi = b;
        return (hi < 0) ? 1 : (hi / CHUNK) + 1;
    endfunction

    task automatic drive_valid(input bit which, input logic v);
        if (which) in_valid_e = v;
        else       in_valid_f = v;
    endtask

    task automatic run_word(input bit which, input logic [WIDTH-1:0] w,
                            input int hold, input string tag);
        int  lat;
        int  exp_lat;
        bit  seen;
        sel       = which;
        exp_lat   = model_latency(w, which);
        out_ready = (hold == 0);
        in_data   = w;
        check({tag, "_idle_ready"}, s_in_ready, 1);
        drive_valid(which, 1'b1);
        tick();
        drive_valid(which, 1'b0);
        in_data = $urandom();
        check({tag, "_busy"}, s_busy, 1);
        lat  = 0;
        seen = 0;
        while (!seen && lat < 40) begin
            tick();
            lat++;
            seen = s_out_valid;
        end
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_count"}, s_out_count, $countones(w));
        check({tag, "_zero"}, s_out_zero, (w == '0));
        check({tag, "_onehot"}, s_out_onehot, $onehot(w));
        check({tag, "_done_not_ready"}, s_in_ready, 0);
        for (int h = 0; h < hold; h++) begin
            drive_valid(which, 1'b1);
            tick();
            drive_valid(which, 1'b0);
            check({tag, "_hold_valid"}, s_out_valid, 1);
            check({tag, "_hold_count"}, s_out_count, $countones(w));
            check({tag, "_hold_in_ready"}, s_in_ready, 0);
        end
        out_ready = 1'b1;
        tick();
        check({tag, "_drained"}, s_out_valid, 0);
        check({tag, "_ready_again"}, s_in_ready, 1);
        check({tag, "_idle"}, s_busy, 0);
    endtask

    initial begin
        logic [WIDTH-1:0] w;
        bit               no_valid;
        int               mode;

        // Asynchronous reset before any clock edge.
        #2 rst = 1'b1;
        #1;
        check("rst_f_in_ready", f_in_ready, 1);
        check("rst_f_out_valid", f_out_valid, 0);
        check("rst_f_count", f_out_count, 0);
        check("rst_e_flags", {e_out_zero, e_out_onehot, e_busy, e_out_valid}, 4'b0000);
        @(negedge clk);
        rst = 1'b0;
        tick();

        for (int v = 0; v < 16; v++) begin
            chunk_bits = CHUNK'(v);
            #1;
            check("chunk_popcnt", chunk_count, $countones(chunk_bits));
        end

        run_word(1'b0, 32'hFFFF_FFFF, 0, "full_ones");
        run_word(1'b1, 32'h0000_0001, 0, "early_lsb");
        run_word(1'b1, 32'h8000_0000, 0, "early_msb");
        run_word(1'b1, 32'h0000_0000, 0, "early_zero");
        run_word(1'b0, 32'h0000_0000, 0, "full_zero");
        run_word(1'b0, 32'hA5A5_0F0F, 5, "backpressure");

        // Flush mid-BUSY drops the word.
        sel = 1'b0;
        in_data = 32'h1234_5678;
        in_valid_f = 1'b1;
        tick();
        in_valid_f = 1'b0;
        tick();
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_busy_idle", f_busy, 0);
        check("flush_busy_ready", f_in_ready, 1);
        no_valid = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (f_out_valid) no_valid = 1'b0;
            tick();
        end
        check("flush_no_result", no_valid, 1);
        run_word(1'b0, 32'h0000_000F, 0, "after_flush");

        // Flush with in_valid in IDLE: not accepted.
        flush = 1'b1;
        in_valid_f = 1'b1;
        tick();
        flush = 1'b0;
        in_valid_f = 1'b0;
        check("flush_idle_reject", f_busy, 0);

        // Flush drops a pending result in DONE.
        sel = 1'b1;
        out_ready = 1'b0;
        in_data = 32'h0000_0003;
        in_valid_e = 1'b1;
        tick();
        in_valid_e = 1'b0;
        tick();
        tick();
        check("flush_done_pending", e_out_valid, 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        out_ready = 1'b1;
        check("flush_done_drop", e_out_valid, 0);
        check("flush_done_idle", e_busy, 0);

        // Asynchronous reset mid-BUSY, between clock edges.
        in_data = 32'hFFFF_FFFF;
        in_valid_e = 1'b1;
        tick();
        in_valid_e = 1'b0;
        tick();
        #2 rst = 1'b1;
        #1;
        check("rst_mid_busy", {e_in_ready, e_out_valid, e_out_zero, e_out_onehot, e_busy}, 5'b10000);
        check("rst_mid_count", e_out_count, 0);
        #1 rst = 1'b0;
        tick();
        check("rst_after_valid", e_out_valid, 0);

        for (int n = 0; n < 40; n++) begin
            mode = $urandom_range(0, 3);
            case (mode)
                0:       w = $urandom();
                1:       w = 32'h1 << $urandom_range(0, WIDTH - 1);
                2:       w = $urandom() & (32'hFFFF_FFFF >> $urandom_range(0, WIDTH - 1));
                default: w = '0;
            endcase
            run_word(1'($urandom_range(0, 1)), w,
                     ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
